// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared channel constants for the RGB PWM fader
package led_pkg;
  localparam int NUM_CH = 3;
  localparam int CH_R   = 0;
  localparam int CH_G   = 1;
  localparam int CH_B   = 2;
endpackage

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one colour channel: duty ramp, period-aligned shadow, compare and pin register
module pwm_channel #(
  parameter int PWM_BITS   = 8,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                clk24,
  input  logic                rst,
  input  logic                tick_i,
  input  logic                period_end_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  input  logic                target_i,
  output logic                led_o,
  output logic [PWM_BITS-1:0] duty_o
);
  localparam logic [PWM_BITS-1:0] DMAX = '1;
  localparam logic [PWM_BITS-1:0] ONE  = PWM_BITS'(1);

  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] act_q, act_d;
  logic                led_q, led_d;
  logic                lit;

  always_comb begin
    duty_d = duty_q;
    if (tick_i) begin
      if (target_i && duty_q != DMAX)       duty_d = duty_q + ONE;
      else if (!target_i && duty_q != '0)   duty_d = duty_q - ONE;
    end
    // Shadow takes the pre-tick duty so a period never changes mid-flight.
    act_d = period_end_i ? duty_q : act_q;
    lit   = (act_q == DMAX) || (pwm_cnt_i < act_q);
    led_d = lit ^ ACTIVE_LOW;
  end

  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      duty_q <= '0;
      act_q  <= '0;
      led_q  <= ACTIVE_LOW;
    end else begin
      duty_q <= duty_d;
      act_q  <= act_d;
      led_q  <= led_d;
    end
  end

  assign led_o  = led_q;
  assign duty_o = duty_q;
endmodule

// File: rtl/rgb_pwm_fader.sv
// rtl/rgb_pwm_fader.sv - shared PWM counter, fade prescaler and busy flag around three pwm_channels
module rgb_pwm_fader
  import led_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int STEP_DIV   = 4096,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk24,
  input  logic       rst,
  input  logic [2:0] target,
  input  logic       enable,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b,
  output logic       busy
);
  localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] DMAX     = '1;

  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic                busy_q, busy_d;
  logic                tick, period_end;
  logic [NUM_CH-1:0]   led;
  logic [PWM_BITS-1:0] duty [NUM_CH];

  assign tick       = enable && (pre_q == PRE_LAST);
  assign period_end = (cnt_q == DMAX);

  always_comb begin
    cnt_d  = cnt_q + PWM_BITS'(1);
    pre_d  = pre_q;
    if (enable) pre_d = tick ? '0 : pre_q + PRE_W'(1);
    busy_d = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (duty[c] != (target[c] ? DMAX : '0)) busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      pre_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pre_q  <= pre_d;
      busy_q <= busy_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_channel #(
      .PWM_BITS  (PWM_BITS),
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_ch (
      .clk24       (clk24),
      .rst         (rst),
      .tick_i      (tick),
      .period_end_i(period_end),
      .pwm_cnt_i   (cnt_q),
      .target_i    (target[g]),
      .led_o       (led[g]),
      .duty_o      (duty[g])
    );
  end

  assign led_r = led[CH_R];
  assign led_g = led[CH_G];
  assign led_b = led[CH_B];
  assign busy  = busy_q;
endmodule
